// File: rtl/lz77_encoder.sv
// Greedy LZ77 encoder: captures a '$'-terminated 2048-symbol hex string, then emits
// (offset, match_len, char_nxt) codewords from a sliding 9+8 symbol register window.
module lz77_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  output logic       valid,
  output logic       encode,
  output logic       finish,
  output logic [3:0] offset,
  output logic [2:0] match_len,
  output logic [7:0] char_nxt
);
  localparam int unsigned STR_LEN    = 2048;
  localparam int unsigned SEARCH_LEN = 9;
  localparam int unsigned LOOK_LEN   = 8;
  localparam int unsigned BUF_LEN    = SEARCH_LEN + LOOK_LEN;
  localparam int unsigned IDX_W      = $clog2(STR_LEN + 1);
  localparam int unsigned MAX_L      = LOOK_LEN - 1;
  localparam logic [7:0]  TERM       = 8'h24;
  localparam logic [4:0]  TERM_SYM   = 5'h10;

  typedef enum logic [2:0] {S_IN, S_FILL, S_CMP, S_SHIFT, S_HOLD, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   p_q, p_d;
  logic [3:0]         sh_q, sh_d;
  logic [4:0]         win_q [BUF_LEN];
  logic [4:0]         win_d [BUF_LEN];
  logic [4:0]         shift_c [BUF_LEN];
  logic               valid_q, valid_d, encode_q, encode_d, finish_q, finish_d;
  logic [3:0]         offset_q, offset_d;
  logic [2:0]         len_q, len_d;
  logic [7:0]         char_q, char_d;

  // Symbol store: bit 4 flags the terminator, bits 3:0 hold the hex value
  logic [4:0]         mem_q [0:STR_LEN];
  logic [4:0]         in_sym_c, rd_sym_c, nxt_sym_c;
  logic [IDX_W-1:0]   rem_c;
  logic [2:0]         cap_c, cur_l_c, best_l_c;
  logic [3:0]         best_o_c;
  logic               hit_c;
  logic [7:0]         char_c;

  assign in_sym_c = (chardata == TERM) ? TERM_SYM : {1'b0, chardata[3:0]};
  assign rd_sym_c = (idx_q <= IDX_W'(STR_LEN)) ? mem_q[idx_q] : TERM_SYM;

  always_ff @(posedge clk) begin
    if (state_q == S_IN) mem_q[idx_q] <= in_sym_c;
  end

  // win[SEARCH_LEN+k] = str[p+k]; win[SEARCH_LEN-1-o] = str[p-1-o]
  always_comb begin
    for (int j = 0; j < BUF_LEN - 1; j++) shift_c[5'(j)] = win_q[5'(j + 1)];
    shift_c[5'(BUF_LEN - 1)] = rd_sym_c;
  end

  // Longest legal match over all offsets; strict '>' keeps the smallest offset on ties
  always_comb begin
    rem_c    = IDX_W'(STR_LEN) - p_q;
    cap_c    = (rem_c >= IDX_W'(MAX_L)) ? 3'(MAX_L) : rem_c[2:0];
    best_o_c = '0;
    best_l_c = '0;
    hit_c    = 1'b0;
    cur_l_c  = '0;
    for (int o = 0; o < SEARCH_LEN; o++) begin
      hit_c   = (p_q > IDX_W'(o));
      cur_l_c = '0;
      for (int k = 0; k < MAX_L; k++) begin
        hit_c = hit_c && (3'(k) < cap_c) &&
                (win_q[5'(SEARCH_LEN - 1 - o + k)] == win_q[5'(SEARCH_LEN + k)]);
        if (hit_c) cur_l_c = cur_l_c + 3'd1;
      end
      if (cur_l_c > best_l_c) begin
        best_l_c = cur_l_c;
        best_o_c = 4'(o);
      end
    end
    nxt_sym_c = win_q[5'(SEARCH_LEN) + 5'(best_l_c)];
    char_c    = nxt_sym_c[4] ? TERM : {4'h0, nxt_sym_c[3:0]};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    p_d      = p_q;
    sh_d     = sh_q;
    win_d    = win_q;
    valid_d  = 1'b0;
    encode_d = 1'b0;
    finish_d = 1'b0;
    offset_d = offset_q;
    len_d    = len_q;
    char_d   = char_q;
    case (state_q)
      S_IN: begin
        if (idx_q == IDX_W'(STR_LEN)) begin
          state_d = S_FILL;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_FILL: begin
        win_d = shift_c;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LOOK_LEN - 1)) state_d = S_CMP;
      end
      S_CMP: begin
        valid_d  = 1'b1;
        encode_d = 1'b1;
        offset_d = best_o_c;
        len_d    = best_l_c;
        char_d   = char_c;
        p_d      = p_q + IDX_W'(best_l_c) + IDX_W'(1);
        sh_d     = 4'(best_l_c) + 4'd1;
        state_d  = nxt_sym_c[4] ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        win_d = shift_c;
        idx_d = idx_q + IDX_W'(1);
        sh_d  = sh_q - 4'd1;
        if (sh_q == 4'd1) state_d = S_HOLD;
      end
      S_HOLD: state_d = S_CMP;
      S_DONE: finish_d = 1'b1;
      default: state_d = S_IN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IN;
      idx_q    <= '0;
      p_q      <= '0;
      sh_q     <= '0;
      win_q    <= '{default: '0};
      valid_q  <= 1'b0;
      encode_q <= 1'b0;
      finish_q <= 1'b0;
      offset_q <= '0;
      len_q    <= '0;
      char_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      p_q      <= p_d;
      sh_q     <= sh_d;
      win_q    <= win_d;
      valid_q  <= valid_d;
      encode_q <= encode_d;
      finish_q <= finish_d;
      offset_q <= offset_d;
      len_q    <= len_d;
      char_q   <= char_d;
    end
  end

  assign valid     = valid_q;
  assign encode    = encode_q;
  assign finish    = finish_q;
  assign offset    = offset_q;
  assign match_len = len_q;
  assign char_nxt  = char_q;
endmodule

// File: tb/tb_lz77_encoder.sv
// Bench for lz77_encoder: directed and random images compared against a greedy LZ77 reference.
module tb_lz77_encoder;
  localparam int STR_LEN = 2048;
  localparam int MAX_CYC = 30000;

  typedef struct packed {
    logic [3:0] o;
    logic [2:0] l;
    logic [7:0] c;
  } cw_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] chardata = 8'h00;
  logic       valid, encode, finish;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_nxt;

  int  img [0:STR_LEN];
  cw_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n_cw;

  always #5 clk = ~clk;

  lz77_encoder dut (
    .clk(clk), .reset(reset), .chardata(chardata),
    .valid(valid), .encode(encode), .finish(finish),
    .offset(offset), .match_len(match_len), .char_nxt(char_nxt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Greedy reference straight from the string: scan every legal source, keep the longest run
  function automatic void ref_model();
    int p, cap, bo, bl, l, src;
    exp_q.delete();
    p = 0;
    while (1) begin
      cap = (STR_LEN - p < 7) ? STR_LEN - p : 7;
      bo = 0;
      bl = 0;
      for (int o = 0; o < 9; o++) begin
        src = p - 1 - o;
        if (src >= 0) begin
          l = 0;
          while (l < cap && img[src + l] == img[p + l]) l++;
          if (l > bl) begin
            bl = l;
            bo = o;
          end
        end
      end
      exp_q.push_back({4'(bo), 3'(bl), 8'(img[p + bl])});
      if (p + bl == STR_LEN) break;
      p += bl + 1;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {valid, encode, finish, offset, match_len, char_nxt}, 0);
  endtask

  task automatic feed();
    reset = 1'b1;
    for (int i = 0; i <= STR_LEN; i++) begin
      chardata = 8'(img[i]);
      @(negedge clk);
    end
    chardata = 8'h0;
  endtask

  task automatic collect(output int n);
    int  gap;
    bit  done, prev_term;
    cw_t got, e;
    n = 0;
    gap = 0;
    done = 0;
    prev_term = 0;
    for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
      check("encode_eq_valid", encode, valid);
      if (finish) begin
        check("finish_after_last", prev_term, 1);
        check("finish_not_valid", valid, 0);
        done = 1;
      end else if (valid) begin
        check("valid_spacing", (gap >= 2 && gap <= 20), 1);
        got = {offset, match_len, char_nxt};
        e = (n < exp_q.size()) ? exp_q[n] : '1;
        check($sformatf("codeword_%0d", n), got, e);
        n++;
        gap = 0;
      end else begin
        gap++;
      end
      prev_term = valid && (char_nxt == 8'h24);
      if (!done) @(negedge clk);
    end
    check("finish_seen", done, 1);
    check("codeword_count", n, exp_q.size());
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("finish_sticky", {finish, valid, encode}, 3'b100);
    end
  endtask

  task automatic run_image(output int n);
    img[STR_LEN] = 8'h24;
    ref_model();
    do_reset();
    feed();
    collect(n);
  endtask

  initial begin
    // all zeros
    for (int i = 0; i < STR_LEN; i++) img[i] = 0;
    run_image(n_cw);
    check("zeros_count", n_cw, 257);

    // period 16 exceeds the window: all literals
    for (int i = 0; i < STR_LEN; i++) img[i] = i % 16;
    run_image(n_cw);
    check("cyclic16_count", n_cw, 2049);

    // "01" repeated: overlapping matches, tie-break to smallest offset
    for (int i = 0; i < STR_LEN; i++) img[i] = i % 2;
    run_image(n_cw);

    // random binary, random full hex
    for (int i = 0; i < STR_LEN; i++) img[i] = int'($urandom_range(0, 1));
    run_image(n_cw);
    for (int i = 0; i < STR_LEN; i++) img[i] = int'($urandom_range(0, 15));
    run_image(n_cw);

    // tail "7777" forces the length cap at the end of the string
    for (int i = 0; i < STR_LEN; i++) img[i] = (i >= STR_LEN - 4) ? 7 : int'($urandom_range(0, 3));
    run_image(n_cw);

    // reset asserted mid-encode, then the same image is re-fed
    for (int i = 0; i < STR_LEN; i++) img[i] = int'($urandom_range(0, 3));
    img[STR_LEN] = 8'h24;
    ref_model();
    do_reset();
    feed();
    repeat (300) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("midenc_reset_async", {valid, encode, finish, offset, match_len, char_nxt}, 0);
    run_image(n_cw);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
